// File: rtl/wb_pkg.sv
// Shared Wishbone B4 encodings (CTI/BTE) and the burst RAM slave FSM state type.
package wb_pkg;

  localparam int unsigned CTI_W  = 3;
  localparam int unsigned BTE_W  = 2;
  localparam int unsigned WCNT_W = 4;

  localparam logic [CTI_W-1:0] CTI_CLASSIC = 3'b000;
  localparam logic [CTI_W-1:0] CTI_CONST   = 3'b001;
  localparam logic [CTI_W-1:0] CTI_INC     = 3'b010;
  localparam logic [CTI_W-1:0] CTI_END     = 3'b111;

  localparam logic [BTE_W-1:0] BTE_LINEAR  = 2'b00;
  localparam logic [BTE_W-1:0] BTE_WRAP4   = 2'b01;
  localparam logic [BTE_W-1:0] BTE_WRAP8   = 2'b10;
  localparam logic [BTE_W-1:0] BTE_WRAP16  = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_BURST = 2'd2,
    ST_DEAD  = 2'd3
  } wb_state_e;

endpackage

// File: rtl/wb_burst_ram_slave_if.sv
// Wishbone B4 slave-slot signal bundle; master drives *_i, slave drives *_o.
interface wb_burst_ram_slave_if #(
  parameter int unsigned Dw   = 32,
  parameter int unsigned Aw   = 32,
  parameter int unsigned SELw = 4,
  parameter int unsigned TAGw = 3,
  parameter int unsigned CTIw = 3,
  parameter int unsigned BTEw = 2
) ();

  logic [Aw-1:0]   sa_adr_i;
  logic [Dw-1:0]   sa_dat_i;
  logic [SELw-1:0] sa_sel_i;
  logic [TAGw-1:0] sa_tag_i;
  logic [CTIw-1:0] sa_cti_i;
  logic [BTEw-1:0] sa_bte_i;
  logic            sa_we_i;
  logic            sa_stb_i;
  logic            sa_cyc_i;
  logic [Dw-1:0]   sa_dat_o;
  logic            sa_ack_o;
  logic            sa_err_o;
  logic            sa_rty_o;

  modport slave (
    input  sa_adr_i, sa_dat_i, sa_sel_i, sa_tag_i, sa_cti_i, sa_bte_i,
    input  sa_we_i, sa_stb_i, sa_cyc_i,
    output sa_dat_o, sa_ack_o, sa_err_o, sa_rty_o
  );

  modport master (
    output sa_adr_i, sa_dat_i, sa_sel_i, sa_tag_i, sa_cti_i, sa_bte_i,
    output sa_we_i, sa_stb_i, sa_cyc_i,
    input  sa_dat_o, sa_ack_o, sa_err_o, sa_rty_o
  );

endinterface

// File: rtl/wb_burst_addr_gen.sv
// Combinational next-beat word address for Wishbone incrementing bursts (linear / wrap-4/8/16).
module wb_burst_addr_gen
  import wb_pkg::*;
#(
  parameter int unsigned Aw = 32
) (
  input  logic [Aw-1:0]    addr_i,
  input  logic [BTE_W-1:0] bte_i,
  output logic [Aw-1:0]    addr_next_c_o
);

  // Wrapping bursts only advance the low bits; the wrap-block base stays put.
  always_comb begin
    addr_next_c_o = addr_i + Aw'(1);
    case (bte_i)
      BTE_WRAP4:  addr_next_c_o = {addr_i[Aw-1:2], addr_i[1:0] + 2'd1};
      BTE_WRAP8:  addr_next_c_o = {addr_i[Aw-1:3], addr_i[2:0] + 3'd1};
      BTE_WRAP16: addr_next_c_o = {addr_i[Aw-1:4], addr_i[3:0] + 4'd1};
      default:    ;
    endcase
  end

endmodule

// File: rtl/wb_burst_ram_slave.sv
// Wishbone B4 slave with internal single-port RAM: classic cycles with wait states,
// CTI incrementing bursts at one beat per cycle, and error response for out-of-range words.
module wb_burst_ram_slave
  import wb_pkg::*;
#(
  parameter int unsigned Dw          = 32,
  parameter int unsigned Aw          = 32,
  parameter int unsigned SELw        = 4,
  parameter int unsigned TAGw        = 3,
  parameter int unsigned CTIw        = 3,
  parameter int unsigned BTEw        = 2,
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 0
) (
  input logic                clk,
  input logic                reset,
  wb_burst_ram_slave_if.slave sa
);

  localparam int unsigned       IDX_W     = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [Aw:0]       MEM_LIMIT = (Aw+1)'(MEM_WORDS);
  localparam logic [WCNT_W-1:0] WCNT_INIT = WCNT_W'(WAIT_STATES);

  wb_state_e         state_q, state_d;
  logic [WCNT_W-1:0] wcnt_q, wcnt_d;
  logic [Aw-1:0]     addr_q, addr_d;
  logic              ack_q, ack_d;
  logic              err_q, err_d;
  logic [Dw-1:0]     dat_q, dat_d;

  logic [Dw-1:0]     mem_q [MEM_WORDS];

  logic              req_c;
  logic              in_range_c;
  logic              beat_c;
  logic              mem_we_c;
  logic [CTIw-1:0]   cti_in_c;
  logic [BTEw-1:0]   bte_in_c;
  logic [CTI_W-1:0]  cti_c;
  logic [Aw-1:0]     addr_next_c;
  logic [IDX_W-1:0]  idx_c;
  logic [Dw-1:0]     rd_c;
  logic [Dw-1:0]     wr_word_c;
  logic [TAGw-1:0]   unused_tag_c;

  assign req_c        = sa.sa_cyc_i & sa.sa_stb_i;
  assign cti_in_c     = sa.sa_cti_i;
  assign bte_in_c     = sa.sa_bte_i;
  assign cti_c        = CTI_W'(cti_in_c);
  assign unused_tag_c = sa.sa_tag_i;

  // Range check and RAM index always come from the latched burst address.
  assign in_range_c = ({1'b0, addr_q} < MEM_LIMIT);
  assign idx_c      = addr_q[IDX_W-1:0];
  assign rd_c       = mem_q[idx_c];

  wb_burst_addr_gen #(
    .Aw (Aw)
  ) u_addr_gen (
    .addr_i        (addr_q),
    .bte_i         (BTE_W'(bte_in_c)),
    .addr_next_c_o (addr_next_c)
  );

  // Byte-lane merge: unselected lanes keep the current RAM contents.
  for (genvar g = 0; g < SELw; g++) begin : g_lane
    assign wr_word_c[8*g +: 8] = sa.sa_sel_i[g] ? sa.sa_dat_i[8*g +: 8] : rd_c[8*g +: 8];
  end

  always_comb begin
    state_d  = state_q;
    wcnt_d   = wcnt_q;
    addr_d   = addr_q;
    ack_d    = 1'b0;
    err_d    = 1'b0;
    dat_d    = dat_q;
    mem_we_c = 1'b0;
    beat_c   = req_c && (((state_q == ST_WAIT) && (wcnt_q == '0)) || (state_q == ST_BURST));

    case (state_q)
      ST_IDLE: begin
        if (req_c) begin
          addr_d  = sa.sa_adr_i;
          wcnt_d  = WCNT_INIT;
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (req_c && (wcnt_q != '0)) begin
          wcnt_d = wcnt_q - WCNT_W'(1);
        end
      end
      ST_BURST: ;
      ST_DEAD:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase

    // One beat is answered per cycle; only INC keeps the burst open.
    if (beat_c) begin
      if (!in_range_c) begin
        err_d   = 1'b1;
        dat_d   = '0;
        state_d = ST_DEAD;
      end else begin
        ack_d    = 1'b1;
        dat_d    = rd_c;
        mem_we_c = sa.sa_we_i;
        addr_d   = addr_next_c;
        state_d  = (cti_c == CTI_INC) ? ST_BURST : ST_DEAD;
      end
    end

    // Cycle abort overrides everything, including a beat decided above.
    if (!sa.sa_cyc_i) begin
      state_d  = ST_IDLE;
      ack_d    = 1'b0;
      err_d    = 1'b0;
      dat_d    = dat_q;
      mem_we_c = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
      ack_q   <= 1'b0;
      err_q   <= 1'b0;
      dat_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      dat_q   <= dat_d;
    end
  end

  // RAM array carries no reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem_q[idx_c] <= wr_word_c;
    end
  end

  assign sa.sa_ack_o = ack_q;
  assign sa.sa_err_o = err_q;
  assign sa.sa_dat_o = dat_q;
  assign sa.sa_rty_o = 1'b0;

endmodule

// File: tb/tb_wb_burst_ram_slave.sv
// Scoreboard bench for wb_burst_ram_slave: two instances (0 and 3 wait states) share one master.
module tb_wb_burst_ram_slave;
  import wb_pkg::*;

  typedef struct {
    int unsigned cyc;
    bit          err;
    bit          chk;
    int unsigned dat;
  } exp_t;

  logic        clk;
  logic        reset;
  logic [31:0] m_adr;
  logic [31:0] m_dat;
  logic [3:0]  m_sel;
  logic [2:0]  m_cti;
  logic [1:0]  m_bte;
  logic        m_we;
  logic        m_stb;
  logic        m_cyc;
  int          tgt;

  int unsigned cyc_cnt = 0;
  int          n_checks = 0;
  int          n_err = 0;
  exp_t        q0[$];
  exp_t        q1[$];
  int unsigned wd [16];
  int unsigned ed [16];

  wb_burst_ram_slave_if bus0 ();
  wb_burst_ram_slave_if bus1 ();

  assign bus0.sa_adr_i = m_adr;  assign bus1.sa_adr_i = m_adr;
  assign bus0.sa_dat_i = m_dat;  assign bus1.sa_dat_i = m_dat;
  assign bus0.sa_sel_i = m_sel;  assign bus1.sa_sel_i = m_sel;
  assign bus0.sa_tag_i = '0;     assign bus1.sa_tag_i = '0;
  assign bus0.sa_cti_i = m_cti;  assign bus1.sa_cti_i = m_cti;
  assign bus0.sa_bte_i = m_bte;  assign bus1.sa_bte_i = m_bte;
  assign bus0.sa_we_i  = m_we;   assign bus1.sa_we_i  = m_we;
  assign bus0.sa_stb_i = m_stb & (tgt == 0);
  assign bus1.sa_stb_i = m_stb & (tgt == 1);
  assign bus0.sa_cyc_i = m_cyc & (tgt == 0);
  assign bus1.sa_cyc_i = m_cyc & (tgt == 1);

  wb_burst_ram_slave #(.MEM_WORDS(1024), .WAIT_STATES(0)) dut0 (
    .clk   (clk),
    .reset (reset),
    .sa    (bus0)
  );

  wb_burst_ram_slave #(.MEM_WORDS(1024), .WAIT_STATES(3)) dut1 (
    .clk   (clk),
    .reset (reset),
    .sa    (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

  function automatic int unsigned ws_of(input int t);
    return (t == 0) ? 0 : 3;
  endfunction

  function automatic void push(input int t, input int unsigned c, input bit e, input bit ch,
                               input int unsigned d);
    exp_t x;
    x.cyc = c; x.err = e; x.chk = ch; x.dat = d;
    if (t == 0) q0.push_back(x);
    else        q1.push_back(x);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // Monitor side: every ack/err must match the oldest expected response of that slave.
  task automatic check_resp(input int d, input logic ack, input logic err, input logic [31:0] dat);
    exp_t e;
    bit   have;
    have = (d == 0) ? (q0.size() != 0) : (q1.size() != 0);
    n_checks++;
    if (!have) begin
      n_err++;
      $display("FAIL resp%0d unexpected: ack=%0b err=%0b at cycle %0d, expected no response",
               d, ack, err, cyc_cnt);
      return;
    end
    e = (d == 0) ? q0.pop_front() : q1.pop_front();
    if (cyc_cnt != e.cyc || ack !== !e.err || err !== e.err) begin
      n_err++;
      $display("FAIL resp%0d kind/time: ack=%0b err=%0b cycle %0d, expected ack=%0b err=%0b cycle %0d",
               d, ack, err, cyc_cnt, !e.err, e.err, e.cyc);
    end
    if (e.chk) begin
      n_checks++;
      if (dat !== e.dat) begin
        n_err++;
        $display("FAIL resp%0d data: got %h, expected %h at cycle %0d", d, dat, e.dat, cyc_cnt);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset) begin
      if (bus0.sa_ack_o || bus0.sa_err_o) check_resp(0, bus0.sa_ack_o, bus0.sa_err_o, bus0.sa_dat_o);
      if (bus1.sa_ack_o || bus1.sa_err_o) check_resp(1, bus1.sa_ack_o, bus1.sa_err_o, bus1.sa_dat_o);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    m_cyc = 1'b0;
    m_stb = 1'b0;
    tick();
  endtask

  // Classic cycle held until one edge after the expected ack.
  task automatic classic(input int t, input bit we, input int unsigned adr, input int unsigned dat,
                         input logic [3:0] sel, input bit e_err, input bit e_chk,
                         input int unsigned e_dat);
    int unsigned w;
    w = ws_of(t);
    tgt = t; m_adr = adr; m_dat = dat; m_sel = sel; m_we = we;
    m_cti = CTI_CLASSIC; m_bte = BTE_LINEAR; m_cyc = 1'b1; m_stb = 1'b1;
    push(t, cyc_cnt + w + 2, e_err, e_chk, e_dat);
    repeat (w + 3) tick();
  endtask

  // Burst of n beats (data wd[], expected read data ed[]); mode 0 ends with END/err,
  // mode 1 drops cyc right after the last beat, mode 2 leaves the bus asserted.
  task automatic burst(input int t, input bit we, input int unsigned adr, input logic [1:0] bte,
                       input int n, input int err_at, input int mode);
    int unsigned w;
    int unsigned base;
    w = ws_of(t);
    tgt = t; m_adr = adr; m_we = we; m_bte = bte; m_sel = 4'hF;
    m_cyc = 1'b1; m_stb = 1'b1;
    base = cyc_cnt + w + 2;
    for (int k = 0; k < n; k++) begin
      m_dat = wd[k];
      m_cti = (k == n - 1 && mode == 0) ? CTI_END : CTI_INC;
      if (k == err_at) push(t, base + k, 1'b1, 1'b1, 0);
      else             push(t, base + k, 1'b0, !we, ed[k]);
      if (k == 0) repeat (w + 2) tick();
      else        tick();
      if (k == err_at) break;
    end
    if (mode == 0) begin
      tick();
      idle();
    end else if (mode == 1) begin
      idle();
    end
  endtask

  initial begin
    int unsigned n;
    reset = 1'b1;
    m_adr = '0; m_dat = '0; m_sel = '0; m_cti = '0; m_bte = '0;
    m_we = 1'b0; m_stb = 1'b0; m_cyc = 1'b0; tgt = 0;
    @(posedge clk); #1;
    chk("reset ack0", {31'd0, bus0.sa_ack_o}, 0);
    chk("reset err0", {31'd0, bus0.sa_err_o}, 0);
    chk("reset rty0", {31'd0, bus0.sa_rty_o}, 0);
    chk("reset dat0", bus0.sa_dat_o, 0);
    chk("reset ack1", {31'd0, bus1.sa_ack_o}, 0);
    chk("reset dat1", bus1.sa_dat_o, 0);
    tick();
    reset = 1'b0;
    tick();

    // Classic write then back-to-back classic read
    classic(0, 1'b1, 5, 32'hDEADBEEF, 4'hF, 1'b0, 1'b0, 0);
    classic(0, 1'b0, 5, 0, 4'hF, 1'b0, 1'b1, 32'hDEADBEEF);
    idle();

    // Byte-lane write, then an all-lanes-off write that must change nothing
    classic(0, 1'b1, 5, 32'h0000_5500, 4'b0010, 1'b0, 1'b0, 0);
    idle();
    classic(0, 1'b0, 5, 0, 4'hF, 1'b0, 1'b1, 32'hDEAD55EF);
    idle();
    classic(0, 1'b1, 5, 32'h1234_5678, 4'b0000, 1'b0, 1'b0, 0);
    idle();
    classic(0, 1'b0, 5, 0, 4'hF, 1'b0, 1'b1, 32'hDEAD55EF);
    idle();

    // Linear burst write 1..4 at 8, then burst read back
    wd = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    burst(0, 1'b1, 8, BTE_LINEAR, 4, -1, 0);
    ed = '{1, 2, 3, 4, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    burst(0, 1'b0, 8, BTE_LINEAR, 4, -1, 0);

    // mem[k] = k for k in 0..15, then wrap-8 from 14 and wrap-4 from 6
    wd = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 9, 10, 11, 12, 13, 14, 15};
    burst(0, 1'b1, 0, BTE_LINEAR, 16, -1, 0);
    ed = '{14, 15, 8, 9, 10, 11, 12, 13, 0, 0, 0, 0, 0, 0, 0, 0};
    burst(0, 1'b0, 14, BTE_WRAP8, 8, -1, 0);
    ed = '{6, 7, 4, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    burst(0, 1'b0, 6, BTE_WRAP4, 4, -1, 0);

    // Range boundary: top two words, out-of-range read, burst running off the end
    classic(0, 1'b1, 1022, 32'hA5A5_0001, 4'hF, 1'b0, 1'b0, 0);
    idle();
    classic(0, 1'b1, 1023, 32'hA5A5_0002, 4'hF, 1'b0, 1'b0, 0);
    idle();
    classic(0, 1'b0, 1024, 0, 4'hF, 1'b1, 1'b1, 0);
    idle();
    ed = '{32'hA5A5_0001, 32'hA5A5_0002, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    burst(0, 1'b0, 1022, BTE_LINEAR, 3, 2, 0);
    classic(0, 1'b0, 1023, 0, 4'hF, 1'b0, 1'b1, 32'hA5A5_0002);
    idle();

    // Three wait states: preload, then a read with stb dropped for two WAIT cycles
    wd = '{11, 22, 33, 44, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    burst(1, 1'b1, 0, BTE_LINEAR, 4, -1, 0);
    tgt = 1; m_adr = 2; m_we = 1'b0; m_cti = CTI_CLASSIC; m_sel = 4'hF;
    m_cyc = 1'b1; m_stb = 1'b1;
    n = cyc_cnt;
    push(1, n + 7, 1'b0, 1'b1, 33);
    tick(); tick();
    m_stb = 1'b0;
    tick(); tick();
    m_stb = 1'b1;
    repeat (4) tick();
    idle();

    // cyc dropped after two burst beats; the next read must start from IDLE
    ed = '{11, 22, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
    burst(1, 1'b0, 0, BTE_LINEAR, 2, -1, 1);
    classic(1, 1'b0, 3, 0, 4'hF, 1'b0, 1'b1, 44);
    idle();

    // Reset asserted mid-burst clears outputs asynchronously
    burst(1, 1'b0, 0, BTE_LINEAR, 2, -1, 2);
    #5;
    reset = 1'b1;
    #1;
    chk("midreset ack1", {31'd0, bus1.sa_ack_o}, 0);
    chk("midreset err1", {31'd0, bus1.sa_err_o}, 0);
    chk("midreset dat1", bus1.sa_dat_o, 0);
    m_cyc = 1'b0; m_stb = 1'b0;
    tick();
    reset = 1'b0;
    tick();
    classic(1, 1'b0, 1, 0, 4'hF, 1'b0, 1'b1, 22);
    idle();
    repeat (3) tick();

    chk("pending0", q0.size(), 0);
    chk("pending1", q1.size(), 0);
    chk("rty0", {31'd0, bus0.sa_rty_o}, 0);
    chk("rty1", {31'd0, bus1.sa_rty_o}, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule

// File: doc/wb_burst_ram_slave.md
Name: wb_burst_ram_slave

Overview:
Wishbone B4 slave responder with internal single-port RAM. It terminates one slave port of the shared wishbone bus interconnect, with one instance per slave slot. Serves classic cycles with a configurable wait-state count and incrementing bursts (CTI/BTE) at one beat per cycle. Out-of-range accesses get an error response instead of an ack.

Parameters:
Dw, 32, data width; must be a multiple of 8
Aw, 32, address width; word address
SELw, 4, byte-select width; must equal Dw/8
TAGw, 3, merged {tga,tgb,tgc}; accepted and ignored
CTIw, 3, cycle type identifier width
BTEw, 2, burst type extension width
MEM_WORDS, 1024, RAM depth in words; any value ≥2, need not be a power of 2
WAIT_STATES, 0, extra cycles before the first ack of any cycle (0..15)

Ports:
clk  in  1  clock
reset  in  1  reset
sa_adr_i  in  Aw  word address
sa_dat_i  in  Dw  write data
sa_sel_i  in  SELw  byte enables
sa_tag_i  in  TAGw  tag, unused
sa_cti_i  in  CTIw  cycle type
sa_bte_i  in  BTEw  burst type
sa_we_i  in  1  write enable
sa_stb_i  in  1  strobe
sa_cyc_i  in  1  cycle
sa_dat_o  out  Dw  read data
sa_ack_o  out  1  acknowledge
sa_err_o  out  1  error
sa_rty_o  out  1  retry; tied 0

Behaviour:
- Reset: reset asynchronous, active-high; clock clk.
  - Outputs sa_ack_o=0, sa_err_o=0, sa_rty_o=0, sa_dat_o=0.
  - FSM to IDLE, wait counter 0.
  - RAM contents are not reset.
- All outputs are registered.
- Request condition: req = sa_cyc_i & sa_stb_i.
- CTI decode:
  - 3'b010 (INC) → burst.
  - 3'b111 (END), 3'b000, 3'b001 and 3'b011..3'b110 → classic.
- Range check: in-range iff sa_adr_i < MEM_WORDS.
- FSM states:
  - IDLE: on req, latch address into addr_cur, load wcnt=WAIT_STATES, go WAIT.
  - WAIT: decrement wcnt while req holds. When wcnt==0 and req:
    - Out of range: assert err for 1 cycle, go DEAD.
    - Classic: assert ack for 1 cycle, go DEAD.
    - INC: assert ack, go BURST.
  - DEAD: ack and err low for one cycle, then IDLE. This prevents a double ack, because the master's stb is still sampled high in the ack cycle.
  - BURST: on each req, ack=1 and addr_cur advances; when stb is low, ack=0 and addr_cur holds.
    - A beat sampled with cti=END is acked, then the FSM goes DEAD.
    - A beat with cti ∉ {INC, END} is acked, then DEAD.
    - If the next address is out of range: err instead of ack, then DEAD.
- Latency:
  - First ack or err: WAIT_STATES+2 cycles after req is first sampled in IDLE.
  - Burst beats: 1 per cycle thereafter.
- Next address (addr_cur, per BTE):
  - 00 linear: +1.
  - 01 wrap-4: low 2 bits increment modulo 4; upper bits fixed.
  - 10 wrap-8: low 3 bits.
  - 11 wrap-16: low 4 bits.
- Writes:
  - On an acked beat with we=1, write mem[addr] byte lanes where sel[i]=1.
  - Error beats never write.
  - sel=0 gives an ack with no change.
- Reads:
  - sa_dat_o = mem[addr] registered in the same cycle the ack is asserted.
  - Returns 0 on err.
  - Holds its value when ack=0.
- sa_cyc_i deasserted in any state → IDLE next cycle; ack and err forced 0 that cycle; no write.
- sa_stb_i dropping in WAIT freezes wcnt; resuming continues the count.
- The address is re-latched only in IDLE. Inside a burst sa_adr_i is ignored except for the range check, which uses the internal address.

Decomposition:
- Shared package wb_pkg:
  - CTI_CLASSIC=3'b000, CTI_CONST=3'b001, CTI_INC=3'b010, CTI_END=3'b111.
  - BTE_LINEAR=2'b00, BTE_WRAP4=2'b01, BTE_WRAP8=2'b10, BTE_WRAP16=2'b11.
  - FSM state encoding.
- Sub-module wb_burst_addr_gen: combinational next-address from (addr_cur, bte). Reusable by a future burst master.

Test Plan:
1. WAIT_STATES=0: classic write adr=5, dat=32'hDEADBEEF, sel=4'hF; then classic read adr=5 → ack 2 cycles after stb, dat_o=32'hDEADBEEF; ack is a 1-cycle pulse with a DEAD gap before the second ack.
2. Byte-lane write adr=5, sel=4'b0010, dat=32'h0000_5500 → later read returns 32'hDEAD55EF.
3. INC burst linear: adr=8, 4 writes 1..4, last beat cti=END; read back burst → acks on 4 consecutive cycles; reads return 1,2,3,4; ack=0 on the cycle after END.
4. Wrap-8 read burst starting adr=14 (mem[k]=k), 8 beats → data 14,15,8,9,10,11,12,13.
5. MEM_WORDS=1024: read adr=1024 → err pulse, ack=0, dat_o=0; linear burst from 1022 → ack,ack,err; mem[1023] intact.
6. WAIT_STATES=3: stb dropped for 2 cycles during WAIT → first ack 5 cycles after req plus 2 stall cycles; cyc drop mid-burst → ack=0 next cycle, FSM IDLE; reset asserted mid-burst → all outputs 0 immediately.
